vga_palette_fetch: RTL



---
 rtl/vga_palette_fetch.sv | 127 ++++++++++++
 1 files changed

// File: rtl/vga_palette_fetch.sv
// Frame-buffer address generator and PRU-programmable palette lookup feeding the VGA colour outputs.
// Latency: 2 cycles from VGA_Read to pix_valid, one pixel per cycle; no backpressure (VGA_Read is never stalled).
module vga_palette_fetch #(
    parameter int          H_ACTIVE = 640,
    parameter int          V_ACTIVE = 480,
    parameter int          BPP      = 2,
    parameter int          ADDR_W   = 19,
    parameter logic [31:0] PAL_BASE = 32'h4000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       pru_addr,
    input  logic [31:0]       pru_data,
    input  logic              color_load,
    input  logic              VGA_Read,
    input  logic              frame_start,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [BPP-1:0]    fb_rd_data,
    output logic [9:0]        pru_red,
    output logic [9:0]        pru_green,
    output logic [9:0]        pru_blue,
    output logic              pix_valid,
    output logic              frame_done
);

    localparam int                NUM       = 1 << BPP;
    localparam int                COL_W     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_ACTIVE - 1);
    localparam logic [31:0]       MODE_ADDR = PAL_BASE + 32'(4 * NUM);

    function automatic logic [29:0] pal_default(input int i);
        case (i)
            0:       pal_default = {10'h30F, 10'h30F, 10'h30F};
            1:       pal_default = {10'h3FF, 10'h000, 10'h000};
            2:       pal_default = {10'h000, 10'h3FF, 10'h000};
            3:       pal_default = {10'h200, 10'h000, 10'h3FF};
            default: pal_default = '0;
        endcase
    endfunction

    logic [ADDR_W-1:0] pix_q, pix_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [COL_W-1:0]  col_req;
    logic [1:0]        mode_q;
    logic [29:0]       pal_q [NUM];
    logic              s1_vld_q;
    logic [BPP-1:0]    s1_col_q;
    logic [BPP-1:0]    pix_idx;
    logic [29:0]       rgb_q;
    logic              vld_q;
    logic              unused_pru_bits;

    assign unused_pru_bits = ^pru_data[31:30];

    // frame_start forces the current request onto pixel 0, so the counters restart at 1 if a read rides along.
    always_comb begin
        pix_d = pix_q;
        col_d = col_q;
        if (frame_start) begin
            pix_d = VGA_Read ? ADDR_W'(1) : '0;
            col_d = VGA_Read ? COL_W'(1) : '0;
        end else if (VGA_Read) begin
            pix_d = (pix_q == PIX_LAST) ? '0 : pix_q + 1'b1;
            col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
        end
    end

    assign col_req    = frame_start ? '0 : col_q;
    assign fb_addr    = frame_start ? '0 : pix_q;
    assign frame_done = VGA_Read && !frame_start && (pix_q == PIX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q    <= '0;
            col_q    <= '0;
            s1_vld_q <= 1'b0;
            s1_col_q <= '0;
        end else begin
            pix_q    <= pix_d;
            col_q    <= col_d;
            s1_vld_q <= VGA_Read;
            if (VGA_Read) begin
                s1_col_q <= col_req[BPP-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= '0;
            for (int i = 0; i < NUM; i++) begin
                pal_q[i] <= pal_default(i);
            end
        end else if (color_load) begin
            if (pru_addr == MODE_ADDR) begin
                mode_q <= pru_data[1:0];
            end
            for (int i = 0; i < NUM; i++) begin
                if (pru_addr == PAL_BASE + 32'(4 * i)) begin
                    pal_q[i] <= pru_data[29:0];
                end
            end
        end
    end

    // Blank outranks test pattern; lookup reads the palette as it stood before this cycle's write.
    assign pix_idx = mode_q[1] ? '0 : (mode_q[0] ? s1_col_q : fb_rd_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= {10'h30F, 10'h30F, 10'h30F};
            vld_q <= 1'b0;
        end else begin
            vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                rgb_q <= pal_q[pix_idx];
            end
        end
    end

    assign pru_red   = rgb_q[29:20];
    assign pru_green = rgb_q[19:10];
    assign pru_blue  = rgb_q[9:0];
    assign pix_valid = vld_q;

endmodule
